lvds_lane_bist: RTL and testbench

//   Parametrised per-lane LVDS datapath core for the board top: retimes NUM_LANES single-ended

---
 rtl/lvds_bist_pkg.sv | 35 +++
 rtl/lvds_prbs7_checker.sv | 133 +++++++++++++
 rtl/lvds_lane_bist.sv | 106 ++++++++++
 tb/tb_lvds_lane_bist.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvds_bist_pkg
// Description : Shared constants, types and helper for the LVDS lane BIST core.
//               Contains the mode encodings, the PRBS7 seed and taps, the
//               loss-of-lock window length, the checker state type and the
//               PRBS7 next-state function.
// Revision    : 1.0 - initial release
// ============================================================================
package lvds_bist_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_GEN  = 2'b01;
  localparam logic [1:0] MODE_CHK  = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  // Feedback taps for x^7 + x^6 + 1 (bit indices of the 7-bit state).
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  localparam int         WIN_LEN     = 64;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  // Shift left and feed the XOR of the two taps into bit 0.
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_prbs7_checker.sv
`default_nettype none
// ============================================================================
// Module      : lvds_prbs7_checker
// Description : Single-lane PRBS7 checker. Searches for lock on the received
//               stream, then free-runs its own predictor and counts bit errors
//               in a saturating counter. Lock is dropped when too many
//               mismatches land inside one window.
// Ports       : clk, rst (async, active-low), active (lane enabled in check
//               mode), din (received bit), err_clr (sync clear of err_cnt),
//               locked (registered lock flag), err_cnt (error count).
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_prbs7_checker
  import lvds_bist_pkg::*;
#(
  parameter int ERR_W    = 16,
  parameter int LOCK_CNT = 32,
  parameter int LOSS_THR = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             din,
  input  logic             err_clr,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int                 c_win_w    = $clog2(WIN_LEN);
  localparam int                 c_mis_w    = 7;
  localparam logic [7:0]         c_lock_cnt = 8'(LOCK_CNT);
  localparam logic [c_mis_w-1:0] c_loss_thr = c_mis_w'(LOSS_THR);
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WIN_LEN - 1);

  chk_state_e         state_q, state_d;
  logic [6:0]         sr_q, sr_d;
  logic [7:0]         match_q, match_d;
  logic [c_win_w-1:0] win_q, win_d;
  logic [c_mis_w-1:0] mis_q, mis_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               w_pred;
  logic               w_miss;
  logic [c_mis_w-1:0] w_mis_inc;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    match_d   = match_q;
    win_d     = win_q;
    mis_d     = mis_q;
    err_d     = err_q;
    w_pred    = sr_q[PRBS7_TAP_A] ^ sr_q[PRBS7_TAP_B];
    w_miss    = (din != w_pred);
    w_mis_inc = mis_q + {{(c_mis_w-1){1'b0}}, w_miss};

    if (!active) begin
      state_d = ST_SEARCH;
      sr_d    = '0;
      match_d = '0;
      win_d   = '0;
      mis_d   = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          sr_d = {sr_q[5:0], din};
          // An all-zero register predicts zero forever, so it must never
          // contribute to lock.
          if (!w_miss && (sr_q != '0)) begin
            if (match_q == (c_lock_cnt - 8'd1)) begin
              state_d = ST_LOCKED;
              match_d = '0;
              win_d   = '0;
              mis_d   = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so one flipped bit is one error.
          sr_d = prbs7_next(sr_q);
          if (w_miss && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
          end
          if (w_mis_inc >= c_loss_thr) begin
            state_d = ST_SEARCH;
            match_d = '0;
            win_d   = '0;
            mis_d   = '0;
          end else if (win_q == c_win_last) begin
            win_d = '0;
            mis_d = '0;
          end else begin
            win_d = win_q + c_win_w'(1);
            mis_d = w_mis_inc;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // Clear takes precedence over any increment in the same cycle.
    if (err_clr) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SEARCH;
      sr_q    <= '0;
      match_q <= '0;
      win_q   <= '0;
      mis_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      match_q <= match_d;
      win_q   <= win_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign locked  = (state_q == ST_LOCKED);
  assign err_cnt = err_q;

endmodule
`default_nettype wire

// File: rtl/lvds_lane_bist.sv
`default_nettype none
// ============================================================================
// Module      : lvds_lane_bist
// Description : Per-lane LVDS datapath core with BIST. Retimes NUM_LANES lanes
//               and offers passthrough, PRBS7 generate, generate+check and an
//               idle 1010 pattern.
// Ports       : clk, rst (async, active-low), mode[1:0], lane_en, inject_err,
//               err_clr, din -> dout (registered), locked (per lane),
//               err_cnt (lane i at [i*ERR_W +: ERR_W]).
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_lane_bist
  import lvds_bist_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ERR_W     = 16,
  parameter int LOCK_CNT  = 32,
  parameter int LOSS_THR  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic [NUM_LANES-1:0]       lane_en,
  input  logic                       inject_err,
  input  logic                       err_clr,
  input  logic [NUM_LANES-1:0]       din,
  output logic [NUM_LANES-1:0]       dout,
  output logic [NUM_LANES-1:0]       locked,
  output logic [NUM_LANES*ERR_W-1:0] err_cnt
);

  logic [1:0]           mode_q, mode_d;
  logic [6:0]           gen_q, gen_d;
  logic                 idle_q, idle_d;
  logic [NUM_LANES-1:0] dout_q, dout_d;

  logic                 w_mode_chg;
  logic [6:0]           w_gen_cur;
  logic                 w_idle_cur;
  logic                 w_bit;
  logic [NUM_LANES-1:0] w_chk_active;

  always_comb begin
    mode_d     = mode;
    w_mode_chg = (mode != mode_q);
    // On the entry cycle the generator and toggle act as if already reset,
    // so the first bit out after a mode change is the seed / idle 0.
    w_gen_cur  = w_mode_chg ? PRBS7_SEED : gen_q;
    w_idle_cur = w_mode_chg ? 1'b0 : idle_q;
    gen_d      = w_gen_cur;
    idle_d     = w_idle_cur;
    w_bit      = 1'b0;

    case (mode)
      MODE_GEN, MODE_CHK: begin
        w_bit = w_gen_cur[6] ^ inject_err;
        gen_d = prbs7_next(w_gen_cur);
      end
      MODE_IDLE: begin
        w_bit  = w_idle_cur;
        idle_d = ~w_idle_cur;
      end
      default: ;
    endcase

    dout_d = (mode == MODE_PASS) ? din : {NUM_LANES{w_bit}};
    dout_d = dout_d & lane_en;

    // Checkers sit in SEARCH outside check mode and during the change cycle.
    w_chk_active = ((mode == MODE_CHK) && !w_mode_chg) ? lane_en : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_PASS;
      gen_q  <= PRBS7_SEED;
      idle_q <= 1'b0;
      dout_q <= '0;
    end else begin
      mode_q <= mode_d;
      gen_q  <= gen_d;
      idle_q <= idle_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lvds_prbs7_checker #(
      .ERR_W    (ERR_W),
      .LOCK_CNT (LOCK_CNT),
      .LOSS_THR (LOSS_THR)
    ) u_chk (
      .clk     (clk),
      .rst     (rst),
      .active  (w_chk_active[i]),
      .din     (din[i]),
      .err_clr (err_clr),
      .locked  (locked[i]),
      .err_cnt (err_cnt[i*ERR_W +: ERR_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_lvds_lane_bist.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lvds_lane_bist
// Description : Scoreboard bench for lvds_lane_bist. Stimulus pushes expected
//               values tagged with the cycle they are due; a monitor compares
//               them against the DUT outputs on the falling edge. A second,
//               single-lane instance (ERR_W=4, LOSS_THR=64) covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_lane_bist;
  import lvds_bist_pkg::*;

  localparam int K_DOUT  = 0;
  localparam int K_LOCK  = 1;
  localparam int K_ERR   = 2;
  localparam int K_LOCK2 = 3;
  localparam int K_ERR2  = 4;
  localparam logic [63:0] M4  = 64'hF;
  localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = MODE_PASS;
  logic [3:0]  lane_en = 4'hF;
  logic        inject_err = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  din;
  logic [3:0]  dout;
  logic [3:0]  locked;
  logic [63:0] err_cnt;
  logic [3:0]  din_drv = 4'h0;
  int          din_sel = 3;

  logic        din2;
  logic        dout2;
  logic        locked2;
  logic [3:0]  err_cnt2;

  always_comb begin
    case (din_sel)
      0:       din = dout;
      1:       din = 4'h0;
      2:       din = 4'hF;
      default: din = din_drv;
    endcase
  end
  assign din2 = dout2;

  lvds_lane_bist #(.NUM_LANES(4), .ERR_W(16), .LOCK_CNT(32), .LOSS_THR(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .lane_en(lane_en), .inject_err(inject_err),
    .err_clr(err_clr), .din(din), .dout(dout), .locked(locked), .err_cnt(err_cnt)
  );

  lvds_lane_bist #(.NUM_LANES(1), .ERR_W(4), .LOCK_CNT(32), .LOSS_THR(64)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .lane_en(lane_en[0]), .inject_err(inject_err),
    .err_clr(err_clr), .din(din2), .dout(dout2), .locked(locked2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] mask;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic expect_at(input int c, input int kind, input logic [63:0] mask,
                           input logic [63:0] val, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.kind = kind; e.mask = mask; e.val = val; e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      K_DOUT:  return {60'd0, dout};
      K_LOCK:  return {60'd0, locked};
      K_ERR:   return err_cnt;
      K_LOCK2: return {63'd0, locked2};
      K_ERR2:  return {60'd0, err_cnt2};
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: pops every expectation due in the current cycle.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [63:0] got;
      e   = sb.pop_front();
      got = observe(e.kind) & e.mask;
      n_vec++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: slot %0d missed at cycle %0d", e.name, e.cyc, cyc);
      end else if (got !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL %s @cycle %0d: got %h, expected %h", e.name, cyc, got, e.val & e.mask);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for the 4-lane lock vector; the check fails if the bound expires.
  task automatic wait_lock(input logic [3:0] want, input int bound, input string nm);
    int k;
    k = 0;
    while (k < bound && locked !== want) begin
      tick();
      k++;
    end
    expect_at(cyc, K_LOCK, M4, {60'd0, want}, nm);
  endtask

  logic [15:0] prbs_ref = 16'hFE04;  // first 16 PRBS7 bits from 7'h7F, first bit at MSB

  initial begin
    // Reset
    tick(3);
    expect_at(cyc, K_DOUT, M4, 64'h0, "rst_dout");
    expect_at(cyc, K_LOCK, M4, 64'h0, "rst_locked");
    expect_at(cyc, K_ERR, M64, 64'h0, "rst_err");
    expect_at(cyc, K_ERR2, M4, 64'h0, "rst_err2");
    tick();
    rst = 1'b1;
    tick(2);

    // Passthrough, one cycle latency
    din_drv = 4'b1010;
    expect_at(cyc, K_DOUT, M4, 64'h0, "pass_pre");
    expect_at(cyc + 1, K_DOUT, M4, 64'hA, "pass_a");
    tick();
    din_drv = 4'b0101;
    expect_at(cyc + 1, K_DOUT, M4, 64'h5, "pass_b");
    tick(2);

    // Generate+check in loopback
    din_sel = 0;
    mode    = MODE_CHK;
    for (int k = 0; k < 16; k++)
      expect_at(cyc + 1 + k, K_DOUT, M4, prbs_ref[15-k] ? 64'hF : 64'h0, "prbs_bit");
    tick();
    wait_lock(4'hF, 40, "lock_time");
    expect_at(cyc, K_LOCK2, 64'h1, 64'h1, "lock_time2");
    for (int b = 0; b < 10; b++) begin
      tick(1000);
      expect_at(cyc, K_ERR, M64, 64'h0, "soak_err");
      expect_at(cyc, K_LOCK, M4, 64'hF, "soak_lock");
    end

    // Single injected error
    inject_err = 1'b1;
    expect_at(cyc + 1, K_ERR, M64, 64'h0, "inj_pre");
    expect_at(cyc + 2, K_ERR, M64, {4{16'd1}}, "inj_err");
    expect_at(cyc + 2, K_ERR2, M4, 64'h1, "inj_err2");
    tick();
    inject_err = 1'b0;
    tick(10);
    expect_at(cyc, K_ERR, M64, {4{16'd1}}, "inj_once");
    expect_at(cyc, K_LOCK, M4, 64'hF, "inj_lock");

    // Disable lane 3, then inject on the remaining lanes
    lane_en = 4'h7;
    expect_at(cyc + 1, K_DOUT, 64'h8, 64'h0, "dis_dout3");
    expect_at(cyc + 1, K_LOCK, M4, 64'h7, "dis_lock");
    tick(5);
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    tick(10);
    expect_at(cyc, K_ERR, M64, {16'd1, 16'd2, 16'd2, 16'd2}, "dis_err_hold");
    expect_at(cyc, K_LOCK, M4, 64'h7, "dis_lock_hold");
    expect_at(cyc, K_ERR2, M4, 64'h2, "dis_err2");
    lane_en = 4'hF;
    tick();
    wait_lock(4'hF, 64, "relock_lane3");

    // Stuck-at-0 then stuck-at-1 input
    din_sel = 1;
    wait_lock(4'h0, 64, "drop_zero");
    for (int k = 0; k < 100; k++) begin
      expect_at(cyc, K_LOCK, M4, 64'h0, "stay_zero");
      tick();
    end
    din_sel = 0;
    wait_lock(4'hF, 64, "relock_a");
    din_sel = 2;
    wait_lock(4'h0, 64, "drop_one");
    for (int k = 0; k < 100; k++) begin
      expect_at(cyc, K_LOCK, M4, 64'h0, "stay_one");
      tick();
    end
    din_sel = 0;
    wait_lock(4'hF, 64, "relock_b");

    // Clear, then 20 spaced injections: 16-bit counters reach 20, 4-bit saturates
    err_clr = 1'b1;
    expect_at(cyc + 1, K_ERR, M64, 64'h0, "clr");
    expect_at(cyc + 1, K_ERR2, M4, 64'h0, "clr2");
    tick();
    err_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      inject_err = 1'b1;
      tick();
      inject_err = 1'b0;
      tick(15);
    end
    tick(3);
    expect_at(cyc, K_ERR, M64, {4{16'd20}}, "err_twenty");
    expect_at(cyc, K_ERR2, M4, 64'hF, "err_sat");
    expect_at(cyc, K_LOCK, M4, 64'hF, "lock_after_inj");
    expect_at(cyc, K_LOCK2, 64'h1, 64'h1, "lock2_after_inj");

    // Clear lands on the same edge as an increment: clear wins
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    err_clr    = 1'b1;
    expect_at(cyc, K_ERR2, M4, 64'hF, "sat_hold");
    expect_at(cyc + 1, K_ERR2, M4, 64'h0, "clr_wins2");
    expect_at(cyc + 1, K_ERR, M64, 64'h0, "clr_wins");
    tick();
    err_clr = 1'b0;
    tick(4);
    expect_at(cyc, K_ERR2, M4, 64'h0, "clr_stays2");
    expect_at(cyc, K_ERR, M64, 64'h0, "clr_stays");

    // Idle pattern
    mode = MODE_IDLE;
    expect_at(cyc + 1, K_DOUT, M4, 64'h0, "idle_0");
    expect_at(cyc + 2, K_DOUT, M4, 64'hF, "idle_1");
    expect_at(cyc + 3, K_DOUT, M4, 64'h0, "idle_2");
    expect_at(cyc + 4, K_DOUT, M4, 64'hF, "idle_3");
    expect_at(cyc + 1, K_LOCK, M4, 64'h0, "idle_unlock");
    tick(6);

    begin
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
        tick();
        guard++;
      end
      if (sb.size() > 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL drain: %0d checks never reached, expected 0", sb.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
